// File: rtl/des_key_schedule.sv
// des_key_schedule: iterative DES subkey generator (PC-1, per-round C/D rotation, PC-2), encrypt or decrypt order.
// Define DES_KEY_PARITY_CHECK_EN to reject keys containing an even-parity byte.
module des_key_schedule #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        start,
  output logic        busy,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_idx,
  output logic        done,
  output logic        key_err
);
  typedef enum logic [1:0] {IDLE, PREP, PRESENT} state_t;
  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                              10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                              14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                              23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // bit r set: round r+1 rotates by one position, otherwise by two
  localparam logic [15:0] ONE_SHIFT = 16'h8103;
  if (NUM_ROUNDS != 16) begin : g_rounds_check
    $error("des_key_schedule: NUM_ROUNDS must be 16");
  end
  state_t      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  rnd_q, rnd_d;
  logic        dir_q, dir_d, busy_q, busy_d, valid_q, valid_d, done_q, done_d, key_err_q, key_err_d;
  logic [55:0] pc1, cd;
  logic        par_bad, last, two;
  function automatic logic [27:0] rot(input logic [27:0] x, input logic dbl, input logic right);
    return right ? (dbl ? {x[1:0], x[27:2]} : {x[0], x[27:1]})
                 : (dbl ? {x[25:0], x[27:26]} : {x[26:0], x[27]});
  endfunction
  assign cd = {c_q, d_q};
  for (genvar g = 0; g < 56; g++) begin : g_pc1
    assign pc1[55-g] = key_in[64-PC1[g]];
  end
  for (genvar g = 0; g < 48; g++) begin : g_pc2
    assign subkey[47-g] = cd[56-PC2[g]];
  end
`ifdef DES_KEY_PARITY_CHECK_EN
  logic [7:0] even_byte;
  for (genvar g = 0; g < 8; g++) begin : g_par
    assign even_byte[g] = ~^key_in[8*g +: 8];
  end
  assign par_bad = |even_byte;
`else
  assign par_bad = 1'b0;
`endif
  assign last = dir_q ? (rnd_q == 4'd0) : (rnd_q == 4'd15);
  // decrypt undoes the rotation that produced the current round; encrypt applies the next round's
  assign two  = ~ONE_SHIFT[dir_q ? rnd_q : rnd_q + 4'd1];
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    d_d       = d_q;
    rnd_d     = rnd_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    key_err_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        key_err_d = par_bad;
        if (!par_bad) begin
          {c_d, d_d} = pc1;
          dir_d      = decrypt;
          state_d    = PREP;
        end
      end
      PREP: begin
        c_d     = dir_q ? c_q : rot(c_q, 1'b0, 1'b0);
        d_d     = dir_q ? d_q : rot(d_q, 1'b0, 1'b0);
        rnd_d   = dir_q ? 4'd15 : 4'd0;
        state_d = PRESENT;
      end
      PRESENT: if (subkey_ready) begin
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          c_d   = rot(c_q, two, dir_q);
          d_d   = rot(d_q, two, dir_q);
          rnd_d = dir_q ? rnd_q - 4'd1 : rnd_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = state_d != IDLE;
    valid_d = state_d == PRESENT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      c_q       <= '0;
      d_q       <= '0;
      rnd_q     <= '0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      d_q       <= d_d;
      rnd_q     <= rnd_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      key_err_q <= key_err_d;
    end
  assign busy         = busy_q;
  assign subkey_valid = valid_q;
  assign round_idx    = rnd_q;
  assign done         = done_q;
  assign key_err      = key_err_q;
endmodule
